// File: rtl/otter_fetch_stage_if.sv
// Instruction-cache fetch bus between the fetch stage and the I-cache.
//   ic_req   : fetch request (master -> cache)
//   ic_addr  : fetch address, held stable while a request is outstanding
//   ic_valid : cache returns ic_data for the current ic_addr
//   ic_data  : instruction word
interface otter_fetch_stage_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_data;

  modport master (output ic_req, ic_addr, input  ic_valid, ic_data);
  modport slave  (input  ic_req, ic_addr, output ic_valid, ic_data);
endinterface

// File: rtl/otter_fetch_stage.sv
// Instruction-fetch stage of the pipelined OTTER MCU.
// Owns the PC, issues fetches to the I-cache and loads the IF/ID register.
// Redirects (branch/jump/trap) flush IF/ID and restart fetch at the target,
// including while a cache miss is outstanding.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   pcSource, branSig redirect select / request from EX
//   bran_val, jal_val, jalr_val, mtvec, mepc  candidate targets
//   stall             decode hazard stall (holds PC and IF/ID)
//   ic                I-cache fetch bus (master side)
//   pc_out            current PC
//   ifid_pc/ir/valid  IF/ID pipeline register
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [2:0]                  pcSource,
  input  logic                        branSig,
  input  logic [31:0]                 bran_val,
  input  logic [31:0]                 jal_val,
  input  logic [31:0]                 jalr_val,
  input  logic [31:0]                 mtvec,
  input  logic [31:0]                 mepc,
  input  logic                        stall,
  otter_fetch_stage_if.master         ic,
  output logic [31:0]                 pc_out,
  output logic [31:0]                 ifid_pc,
  output logic [31:0]                 ifid_ir,
  output logic                        ifid_valid
);

  // FETCH: no request outstanding.  MISS: request accepted, awaiting data.
  // HELD: data arrived under stall, parked in hold_ir.
  // DRAIN: request outstanding but a redirect already happened; data dropped.
  typedef enum logic [1:0] {S_FETCH, S_MISS, S_HELD, S_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
  } ifid_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] hold_ir, hold_ir_n;
  logic [31:0] redir_pc, redir_pc_n;
  ifid_t       ifid, ifid_n;

  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        ic_req_c;

  // Target select; pcSource 0/6/7 never redirects even with branSig high.
  always_comb begin
    tgt   = pc;
    redir = 1'b0;
    case (pcSource)
      3'd1: begin tgt = jalr_val; redir = branSig; end
      3'd2: begin tgt = bran_val; redir = branSig; end
      3'd3: begin tgt = jal_val;  redir = branSig; end
      3'd4: begin tgt = mtvec;    redir = branSig; end
      3'd5: begin tgt = mepc;     redir = branSig; end
      default: begin tgt = pc;    redir = 1'b0;    end
    endcase
  end

  // Wraps modulo 2^32.
  assign pc_inc = pc + 32'd4;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    hold_ir_n  = hold_ir;
    redir_pc_n = redir_pc;
    ifid_n     = ifid;
    ic_req_c   = 1'b0;

    case (state)
      S_FETCH: begin
        // Stall or redirect suppress a fresh request; nothing accepted yet.
        ic_req_c = !stall && !redir;
        if (redir) begin
          pc_n   = tgt;
          ifid_n = '{pc: ifid.pc, ir: NOP_INSTR, valid: 1'b0};
        end else if (!stall) begin
          if (ic.ic_valid) begin
            ifid_n = '{pc: pc, ir: ic.ic_data, valid: 1'b1};
            pc_n   = pc_inc;
          end else begin
            state_n = S_MISS;
          end
        end
      end

      S_MISS: begin
        // Accepted request: keep it up regardless of stall.
        ic_req_c = 1'b1;
        if (redir) begin
          ifid_n = '{pc: ifid.pc, ir: NOP_INSTR, valid: 1'b0};
          if (ic.ic_valid) begin
            pc_n    = tgt;
            state_n = S_FETCH;
          end else begin
            // ic_addr must stay put until the cache answers.
            redir_pc_n = tgt;
            state_n    = S_DRAIN;
          end
        end else if (ic.ic_valid) begin
          if (stall) begin
            hold_ir_n = ic.ic_data;
            state_n   = S_HELD;
          end else begin
            ifid_n  = '{pc: pc, ir: ic.ic_data, valid: 1'b1};
            pc_n    = pc_inc;
            state_n = S_FETCH;
          end
        end
      end

      S_HELD: begin
        if (redir) begin
          pc_n    = tgt;
          ifid_n  = '{pc: ifid.pc, ir: NOP_INSTR, valid: 1'b0};
          state_n = S_FETCH;
        end else if (!stall) begin
          ifid_n  = '{pc: pc, ir: hold_ir, valid: 1'b1};
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end
      end

      S_DRAIN: begin
        ic_req_c = 1'b1;
        if (redir) begin
          redir_pc_n = tgt;
          ifid_n     = '{pc: ifid.pc, ir: NOP_INSTR, valid: 1'b0};
        end
        if (ic.ic_valid) begin
          // A redirect landing on the same edge as the data is the newest.
          pc_n    = redir ? tgt : redir_pc;
          state_n = S_FETCH;
        end
      end

      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_FETCH;
      pc       <= RESET_VECTOR;
      hold_ir  <= 32'd0;
      redir_pc <= 32'd0;
      ifid     <= '{pc: 32'd0, ir: NOP_INSTR, valid: 1'b0};
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      hold_ir  <= hold_ir_n;
      redir_pc <= redir_pc_n;
      ifid     <= ifid_n;
    end
  end

  assign ic.ic_req  = ic_req_c;
  assign ic.ic_addr = pc;
  assign pc_out     = pc;
  assign ifid_pc    = ifid.pc;
  assign ifid_ir    = ifid.ir;
  assign ifid_valid = ifid.valid;

endmodule

// File: tb/tb_otter_fetch_stage.sv
module tb_otter_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  pcSource;
  logic        branSig, stall;
  logic [31:0] bran_val, jal_val, jalr_val, mtvec, mepc;
  logic [31:0] pc_out, ifid_pc, ifid_ir;
  logic        ifid_valid;

  otter_fetch_stage_if ic();

  otter_fetch_stage dut (
    .CLK(CLK), .RST(RST), .pcSource(pcSource), .branSig(branSig),
    .bran_val(bran_val), .jal_val(jal_val), .jalr_val(jalr_val),
    .mtvec(mtvec), .mepc(mepc), .stall(stall), .ic(ic),
    .pc_out(pc_out), .ifid_pc(ifid_pc), .ifid_ir(ifid_ir),
    .ifid_valid(ifid_valid)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks "is a request outstanding", "will its data be thrown away",
  // and "is a word parked waiting for stall release".
  bit          m_known = 0;
  logic [31:0] m_pc;
  bit          m_out, m_drop, m_held;
  logic [31:0] m_newpc, m_hold;
  bit          m_v;
  logic [31:0] m_ir, m_ipc;

  function automatic bit is_redir();
    return branSig && pcSource >= 3'd1 && pcSource <= 3'd5;
  endfunction

  function automatic logic [31:0] sel_tgt();
    case (pcSource)
      3'd1: return jalr_val;
      3'd2: return bran_val;
      3'd3: return jal_val;
      3'd4: return mtvec;
      3'd5: return mepc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_check();
    bit e_req;
    e_req = m_out ? 1'b1 : (m_held ? 1'b0 : (!stall && !is_redir()));
    check("m_ic_req",     {31'd0, ic.ic_req}, {31'd0, e_req});
    check("m_ic_addr",    ic.ic_addr, m_pc);
    check("m_pc_out",     pc_out, m_pc);
    check("m_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_v});
    check("m_ifid_ir",    ifid_ir, m_ir);
    if (m_v) check("m_ifid_pc", ifid_pc, m_ipc);
  endtask

  task automatic m_load(input logic [31:0] w);
    m_ipc = m_pc; m_ir = w; m_v = 1; m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step();
    bit          r;
    logic [31:0] t;
    if (RST) begin
      m_pc = 32'd0; m_out = 0; m_drop = 0; m_held = 0;
      m_v = 0; m_ir = NOP; m_ipc = 32'd0; m_known = 1;
    end else if (m_known) begin
      r = is_redir(); t = sel_tgt();
      if (r) begin
        m_v = 0; m_ir = NOP;
        if (m_out && !ic.ic_valid) begin m_drop = 1; m_newpc = t; end
        else begin m_pc = t; m_out = 0; m_drop = 0; m_held = 0; end
      end else if (m_out && m_drop) begin
        if (ic.ic_valid) begin m_pc = m_newpc; m_out = 0; m_drop = 0; end
      end else if (m_held) begin
        if (!stall) begin m_load(m_hold); m_held = 0; end
      end else if (stall && !m_out) begin
        // no request issued, nothing changes
      end else if (ic.ic_valid) begin
        m_out = 0;
        if (stall) begin m_held = 1; m_hold = ic.ic_data; end
        else m_load(ic.ic_data);
      end else begin
        m_out = 1;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit rst, st, br, input logic [2:0] src,
                       input logic [31:0] t, input bit v, input logic [31:0] d);
    @(negedge CLK);
    RST = rst; stall = st; branSig = br; pcSource = src;
    jalr_val = 32'hDEAD_0010; bran_val = 32'hDEAD_0020; jal_val = 32'hDEAD_0030;
    mtvec    = 32'hDEAD_0040; mepc     = 32'hDEAD_0050;
    case (src)
      3'd1: jalr_val = t;
      3'd2: bran_val = t;
      3'd3: jal_val  = t;
      3'd4: mtvec    = t;
      3'd5: mepc     = t;
      default: ;
    endcase
    ic.ic_valid = v; ic.ic_data = d;
    #1;
  endtask

  task automatic advance();
    @(posedge CLK);
    model_step();
  endtask

  typedef struct {
    bit rst, st, br; logic [2:0] src; logic [31:0] tgt; bit v; logic [31:0] d;
    bit chk; bit er; logic [31:0] ea; bit ev; logic [31:0] eir; logic [31:0] epc;
  } vec_t;

  function automatic vec_t V(bit rst, bit st, bit br, logic [2:0] src, logic [31:0] tgt,
                             bit v, logic [31:0] d, bit chk, bit er, logic [31:0] ea,
                             bit ev, logic [31:0] eir, logic [31:0] epc);
    vec_t x;
    x.rst = rst; x.st = st; x.br = br; x.src = src; x.tgt = tgt; x.v = v; x.d = d;
    x.chk = chk; x.er = er; x.ea = ea; x.ev = ev; x.eir = eir; x.epc = epc;
    return x;
  endfunction

  function automatic logic [31:0] W(int k);
    return 32'hC0DE_0000 + k;
  endfunction

  vec_t tv[$];

  initial begin
    RST = 1; stall = 0; branSig = 0; pcSource = 0;
    bran_val = 0; jal_val = 0; jalr_val = 0; mtvec = 0; mepc = 0;
    ic.ic_valid = 0; ic.ic_data = 0;

    //          rst st br src tgt            v  data    chk req addr          vld ir      ifid_pc
    tv.push_back(V(1,0,0,0,0,               0, 0,      0, 0, 0,            0, NOP,   0));
    // reset state, back-to-back hits
    tv.push_back(V(0,0,0,0,0,               1, W(0),   1, 1, 32'h0,        0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(1),   1, 1, 32'h4,        1, W(0),  32'h0));
    tv.push_back(V(0,0,0,0,0,               1, W(2),   1, 1, 32'h8,        1, W(1),  32'h4));
    tv.push_back(V(0,0,0,0,0,               1, W(3),   1, 1, 32'hC,        1, W(2),  32'h8));
    // branch redirect at pc 0x10 to 0x40
    tv.push_back(V(0,0,1,2,32'h40,          1, W(4),   1, 0, 32'h10,       1, W(3),  32'hC));
    tv.push_back(V(0,0,0,0,0,               1, W(5),   1, 1, 32'h40,       0, NOP,   0));
    // jalr to 0x20, then miss there and trap to mtvec 0x100 mid-miss
    tv.push_back(V(0,0,1,1,32'h20,          0, 0,      1, 0, 32'h44,       1, W(5),  32'h40));
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h20,       0, NOP,   0));
    tv.push_back(V(0,0,1,4,32'h100,         0, 0,      1, 1, 32'h20,       0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h20,       0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(6),   1, 1, 32'h20,       0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(7),   1, 1, 32'h100,      0, NOP,   0));
    // miss at 0x104 returning under stall
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,1,0,0,0,               1, W(8),   1, 1, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,1,0,0,0,               0, 0,      1, 0, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,1,0,0,0,               1, W(9),   1, 0, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 0, 32'h104,      1, W(7),  32'h100));
    tv.push_back(V(0,0,0,0,0,               1, W(10),  1, 1, 32'h108,      1, W(8),  32'h104));
    // two redirects while draining: newest (mepc 0x200) wins
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h10C,      1, W(10), 32'h108));
    tv.push_back(V(0,0,1,2,32'h80,          0, 0,      1, 1, 32'h10C,      1, W(10), 32'h108));
    tv.push_back(V(0,0,1,5,32'h200,         0, 0,      1, 1, 32'h10C,      0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(11),  1, 1, 32'h10C,      0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(12),  1, 1, 32'h200,      0, NOP,   0));
    // PC wrap at 0xFFFF_FFFC
    tv.push_back(V(0,0,1,3,32'hFFFF_FFFC,   1, W(13),  1, 0, 32'h204,      1, W(12), 32'h200));
    tv.push_back(V(0,0,0,0,0,               1, W(14),  1, 1, 32'hFFFF_FFFC,0, NOP,   0));
    tv.push_back(V(0,0,0,0,0,               1, W(15),  1, 1, 32'h0,        1, W(14), 32'hFFFF_FFFC));
    // stall in FETCH suppresses the request
    tv.push_back(V(0,1,0,0,0,               1, W(16),  1, 0, 32'h4,        1, W(15), 32'h0));
    tv.push_back(V(0,0,0,0,0,               1, W(16),  1, 1, 32'h4,        1, W(15), 32'h0));
    // branSig with pcSource 0 / 6 is not a redirect
    tv.push_back(V(0,0,1,0,32'h500,         1, W(17),  1, 1, 32'h8,        1, W(16), 32'h4));
    tv.push_back(V(0,0,1,6,32'h600,         0, 0,      1, 1, 32'hC,        1, W(17), 32'h8));
    // reset in the middle of a miss
    tv.push_back(V(1,0,0,0,0,               0, 0,      1, 1, 32'hC,        1, W(17), 32'h8));
    tv.push_back(V(0,0,0,0,0,               0, 0,      1, 1, 32'h0,        0, NOP,   0));

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].st, tv[i].br, tv[i].src, tv[i].tgt, tv[i].v, tv[i].d);
      if (m_known) model_check();
      if (tv[i].chk) begin
        check($sformatf("v%0d_ic_req", i), {31'd0, ic.ic_req}, {31'd0, tv[i].er});
        check($sformatf("v%0d_ic_addr", i), ic.ic_addr, tv[i].ea);
        check($sformatf("v%0d_ifid_valid", i), {31'd0, ifid_valid}, {31'd0, tv[i].ev});
        check($sformatf("v%0d_ifid_ir", i), ifid_ir, tv[i].eir);
        if (tv[i].ev) check($sformatf("v%0d_ifid_pc", i), ifid_pc, tv[i].epc);
      end
      advance();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_st, r_br, r_v;
      logic [2:0]  r_src;
      logic [31:0] r_t;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      r_br  = ($urandom_range(0, 5) == 0);
      r_src = 3'($urandom_range(0, 7));
      r_t   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      r_v   = ($urandom_range(0, 1) == 1);
      drive(r_rst, r_st, r_br, r_src, r_t, r_v, $urandom);
      if (m_known) model_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/otter_fetch_stage.md
# otter_fetch_stage

Instruction-fetch stage of the pipelined OTTER MCU: owns the program counter, issues fetch requests to the instruction cache, and loads the IF/ID pipeline register. It consumes the redirect decision (pcSource, branSig, bran_val) produced by the execute-stage branch condition generator, plus jump and trap targets. On a redirect it flushes IF/ID and restarts fetch at the target, including redirects that arrive while a cache miss is outstanding.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, ifid_ir value when invalid/flushed (addi x0,x0,0)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- pcSource  in  3  target select: 1 jalr_val, 2 bran_val, 3 jal_val, 4 mtvec, 5 mepc; 0/6/7 = no redirect
- branSig  in  1  redirect request from EX; effective redirect = branSig && pcSource in 1..5
- bran_val, jal_val, jalr_val, mtvec, mepc  in  32 each  candidate targets
- stall  in  1  hazard stall from decode; hold IF/ID and PC
- ic_req  out  1  fetch request to I-cache
- ic_addr  out  32  fetch address (= pc)
- ic_valid  in  1  I-cache returns ic_data for current ic_addr
- ic_data  in  32  instruction word
- pc_out  out  32  current PC register
- ifid_pc  out  32  PC of instruction in IF/ID
- ifid_ir  out  32  instruction in IF/ID
- ifid_valid  out  1  IF/ID holds a live instruction

## Operation
- Registers: pc, state, hold_ir, redir_pc, IF/ID {ifid_pc, ifid_ir, ifid_valid}. redir = effective redirect, tgt = selected target.
- Cache contract: a request is accepted at any edge where ic_req=1 and ic_valid=0; once accepted, ic_addr stays stable and ic_req stays high until ic_valid. ic_valid may be high in the same cycle as ic_req (hit).
- ic_req = (FETCH && !stall && !redir) || MISS || DRAIN. ic_addr = pc always.
- FETCH: redir -> pc<=tgt, ifid_valid<=0, ifid_ir<=NOP_INSTR. Else stall -> hold all. Else ic_valid -> IF/ID<={pc, ic_data, 1}, pc<=pc+4. Else -> MISS.
- MISS: redir && ic_valid -> data dropped, pc<=tgt, flush IF/ID, -> FETCH. redir && !ic_valid -> redir_pc<=tgt, flush IF/ID, -> DRAIN. ic_valid && !stall -> load IF/ID, pc+4, -> FETCH. ic_valid && stall -> hold_ir<=ic_data, -> HELD. Else stay.
- HELD (ic_req=0): redir -> pc<=tgt, flush, -> FETCH. !stall -> IF/ID<={pc, hold_ir, 1}, pc+4, -> FETCH. Else stay.
- DRAIN: IF/ID remains invalid. redir -> redir_pc<=tgt (newest redirect wins). ic_valid -> data dropped, pc<=(redir ? tgt : redir_pc), -> FETCH.
- Priority: RST > redir > stall > advance. Redirect always flushes IF/ID regardless of stall.
- pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0). Targets taken as given; no alignment check.

## Timing
- Reset values: pc=RESET_VECTOR, state=FETCH, ifid_valid=0, ifid_pc=0, ifid_ir=NOP_INSTR, hold_ir=0, redir_pc=0; ic_req=1 in the first cycle after reset (if stall=0, branSig=0).
- Hit latency: instruction presented at edge N appears in IF/ID after edge N; back-to-back hits sustain one instruction/cycle.
- Redirect: branSig at edge N -> ic_addr=target in cycle N+1 (FETCH/MISS-with-valid/HELD); from DRAIN, one cycle after ic_valid.
- Stall does not withdraw an accepted request; stall asserted in FETCH before acceptance suppresses ic_req.
- RST mid-miss: state returns to FETCH immediately; cache must tolerate the abandoned request.

## Test plan
- Reset, RESET_VECTOR=0, cache always hits: ic_addr 0,4,8,…; IF/ID receives each word one cycle later, ifid_valid=1 from second cycle.
- Hit at pc=0x10, branSig=1 pcSource=2 bran_val=0x40: next cycle ic_addr=0x40, ifid_valid=0; following edge IF/ID={0x40, word, 1}.
- Miss at 0x20 (3-cycle), branSig/pcSource=4 mtvec=0x100 in cycle 1: ic_addr stays 0x20 until ic_valid, data discarded, then ic_addr=0x100, ifid_valid stays 0 throughout.
- Miss at 0x30 returns while stall=1 for 2 cycles: ic_req drops, IF/ID unchanged; stall release -> IF/ID={0x30, held word, 1}, pc=0x34.
- Two redirects in DRAIN (pcSource=2 to 0x80, then pcSource=5 mepc=0x200): fetch resumes at 0x200.
- pc=0xFFFF_FFFC hit -> next ic_addr=0x0000_0000.
